sram_rsp_buffer: RTL and testbench

//   Valid/ready front-end for a single-port, 1-cycle-latency tc_sram. Accepts read/write requests,

---
 rtl/sram_rsp_buffer.sv | 127 ++++++++++++
 tb/tb_sram_rsp_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rsp_buffer.sv
// sram_rsp_buffer: valid/ready front-end for a single-port, 1-cycle-latency SRAM.
// Requests pass straight through to the SRAM port when accepted. Read data
// returning one cycle later is captured in a small response FIFO. A credit guard
// makes sure every read in flight already has a FIFO slot reserved, so the
// consumer can stall for as long as it likes without losing data.
module sram_rsp_buffer #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned BufDepth  = 3,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // request side
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    // response side
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    // SRAM port
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntWidth = $clog2(BufDepth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    // Elaboration-time parameter sanity.
    if (BufDepth < 2) begin : g_bad_depth
        $error("sram_rsp_buffer: BufDepth must be at least 2");
    end
    if (ByteWidth != 1 && ByteWidth != 8) begin : g_bad_bytewidth
        $error("sram_rsp_buffer: ByteWidth must be 1 or 8");
    end

    logic                 inflight_q;
    cnt_t                 count_q;
    cnt_t                 count_next;
    ptr_t                 wr_ptr_q;
    ptr_t                 rd_ptr_q;
    logic [DataWidth-1:0] fifo_q [BufDepth];

    cnt_t credits_used;
    logic accept;
    logic push;
    logic pop;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BufDepth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Credit guard and SRAM pass-through: only registered state gates ready.
    always_comb begin
        credits_used = count_q + cnt_t'(inflight_q);
        req_ready_o  = !rst_i && (credits_used < cnt_t'(BufDepth));
        accept       = req_valid_i && req_ready_o;
        sram_req_o   = accept;
        sram_we_o    = accept && req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
    end

    // FIFO handshakes; read data lands in the FIFO the cycle after the read issued.
    always_comb begin
        rsp_valid_o = (count_q != '0);
        rsp_rdata_o = fifo_q[rd_ptr_q];
        push        = inflight_q;
        pop         = rsp_valid_o && rsp_ready_i;
        count_next  = count_q;
        unique case ({push, pop})
            2'b10:   count_next = count_q + cnt_t'(1);
            2'b01:   count_next = count_q - cnt_t'(1);
            default: count_next = count_q;
        endcase
    end

    // Control state: in-flight flag, occupancy and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= accept && !req_we_i;
            count_q    <= count_next;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Response storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BufDepth); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata_i;
        end
    end

    // Simulation checks on address range and FIFO overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!accept || (32'(req_addr_i) < NumWords));
            assert (!(push && !pop && (count_q == cnt_t'(BufDepth))));
        end
    end

endmodule

// File: tb/tb_sram_rsp_buffer.sv
// Bench for sram_rsp_buffer: SRAM behavioural model, transaction-level
// reference (memory image + queue of outstanding read responses), a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_sram_rsp_buffer;

    localparam int NW = 1024;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int AW = 10;
    localparam int BD = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_be_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic [DW-1:0] sram_rdata_i = '0;

    int total = 0;
    int bad   = 0;

    sram_rsp_buffer #(
        .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .BufDepth(BD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d,
                                            input logic [DW-1:0] new_d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return {32'hC0DE0000 | 32'(i), 32'(i * 7), 32'hFACE0000 | 32'(i), ~32'(i)};
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // tc_sram stand-in: write with byte enables, registered read.
    logic [DW-1:0] sram_mem [NW];
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) sram_mem[sram_addr_o] = merge(sram_mem[sram_addr_o], sram_wdata_o, sram_be_o);
            else           sram_rdata_i <= sram_mem[sram_addr_o];
        end
    end

    // Reference: memory image and outstanding reads (in flight or buffered).
    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } ent_t;
    ent_t          q[$];
    logic [DW-1:0] ref_mem [NW];
    int            cyc = 0;
    bit            chk_en = 0;
    logic          m_acc, m_pop, m_rst, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;

    // Compare DUT outputs to the reference mid-cycle.
    always @(negedge clk_i) begin
        logic exp_ready, exp_valid;
        exp_ready = !rst_i && (q.size() < BD);
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        m_acc   = req_valid_i && exp_ready;
        m_pop   = exp_valid && rsp_ready_i;
        m_rst   = rst_i;
        m_we    = req_we_i;
        m_addr  = req_addr_i;
        m_wdata = req_wdata_i;
        m_be    = req_be_i;
        if (chk_en) begin
            check("req_ready", DW'(req_ready_o), DW'(exp_ready));
            check("rsp_valid", DW'(rsp_valid_o), DW'(exp_valid));
            if (exp_valid) check("rsp_rdata", rsp_rdata_o, q[0].data);
            check("sram_req", DW'(sram_req_o), DW'(m_acc));
            check("sram_we", DW'(sram_we_o), DW'(m_acc && m_we));
            if (m_acc) begin
                check("sram_addr", DW'(sram_addr_o), DW'(m_addr));
                if (m_we) begin
                    check("sram_wdata", sram_wdata_o, m_wdata);
                    check("sram_be", DW'(sram_be_o), DW'(m_be));
                end
            end
        end
    end

    // Advance the reference at each clock edge.
    always @(posedge clk_i) begin
        if (m_rst) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                if (m_we) ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_be);
                else      q.push_back('{ref_mem[m_addr], cyc + 2});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input int addr,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = AW'(addr);
        req_wdata_i = d;
        req_be_i    = be;
    endtask

    localparam logic [DW-1:0] DEAD = 128'hDEADBEEF_CAFEF00D_01234567_89ABBEEF;

    initial begin
        int acc_n, got;
        for (int i = 0; i < NW; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        m_acc = 0; m_pop = 0; m_rst = 1; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        rst_i = 1'b1;
        rsp_ready_i = 1'b1;
        drive(0, 0, 0, '0, '0);
        tick();
        chk_en = 1;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state.
        @(negedge clk_i);
        check("rst_ready", DW'(req_ready_o), DW'(1));
        check("rst_valid", DW'(rsp_valid_o), DW'(0));
        check("rst_sram_req", DW'(sram_req_o), DW'(0));
        check("rst_rdata", rsp_rdata_o, '0);

        // Full write then read at address 5: two-cycle latency, one response.
        drive(1, 1, 5, DEAD, '1);
        tick();
        drive(1, 0, 5, '0, '0);
        @(negedge clk_i);
        check("rd5_ready", DW'(req_ready_o), DW'(1));
        tick();
        drive(0, 0, 0, '0, '0);
        @(negedge clk_i);
        check("rd5_lat1", DW'(rsp_valid_o), DW'(0));
        tick();
        @(negedge clk_i);
        check("rd5_lat2", DW'(rsp_valid_o), DW'(1));
        check("rd5_data", rsp_rdata_o, DEAD);
        tick();
        @(negedge clk_i);
        check("rd5_once", DW'(rsp_valid_o), DW'(0));

        // Partial write: only byte 0 of all-ones over zero.
        drive(1, 1, 7, '0, '1);
        tick();
        drive(1, 1, 7, '1, 16'h0001);
        tick();
        drive(1, 0, 7, '0, '0);
        tick();
        drive(0, 0, 0, '0, '0);
        tick();
        @(negedge clk_i);
        check("part_valid", DW'(rsp_valid_o), DW'(1));
        check("part_data", rsp_rdata_o, 128'hFF);
        tick();

        // Fill addresses 100..115 with a pattern.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 100 + i, pat(i), '1);
            tick();
        end
        drive(0, 0, 0, '0, '0);
        tick();

        // 16 back-to-back reads: ready stays high, responses every cycle in order.
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(1, 0, 100 + c, '0, '0);
            else        drive(0, 0, 0, '0, '0);
            @(negedge clk_i);
            if (c < 16) check($sformatf("b2b_ready%0d", c), DW'(req_ready_o), DW'(1));
            if (c >= 2) begin
                check($sformatf("b2b_valid%0d", c - 2), DW'(rsp_valid_o), DW'(1));
                check($sformatf("b2b_data%0d", c - 2), rsp_rdata_o, pat(c - 2));
            end
            tick();
        end

        // Backpressure: exactly BD reads accepted, then drain in order.
        rsp_ready_i = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1, 0, 100 + acc_n, '0, '0);
            @(negedge clk_i);
            if (req_ready_o) acc_n++;
            tick();
        end
        @(negedge clk_i);
        check("bp_accepted", DW'(acc_n), DW'(BD));
        check("bp_ready_low", DW'(req_ready_o), DW'(0));
        tick();
        drive(0, 0, 0, '0, '0);
        rsp_ready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                check($sformatf("bp_drain%0d", got), rsp_rdata_o, pat(got));
                got++;
            end
            tick();
        end
        check("bp_drain_count", DW'(got), DW'(BD));

        // Reset with two entries buffered and one in flight.
        rsp_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 100 + c, '0, '0);
            tick();
        end
        drive(0, 0, 0, '0, '0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_valid", DW'(rsp_valid_o), DW'(0));
        check("mid_rst_ready", DW'(req_ready_o), DW'(1));
        check("mid_rst_rdata", rsp_rdata_o, '0);
        rsp_ready_i = 1'b1;
        drive(1, 0, 5, '0, '0);
        tick();
        drive(0, 0, 0, '0, '0);
        tick();
        @(negedge clk_i);
        check("post_rst_valid", DW'(rsp_valid_o), DW'(1));
        check("post_rst_data", rsp_rdata_o, DEAD);
        tick();

        // Random traffic checked by the reference every cycle.
        for (int c = 0; c < 10000; c++) begin
            rst_i = ($urandom_range(0, 999) == 0);
            rsp_ready_i = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                  int'($urandom_range(0, 31)),
                  {$urandom, $urandom, $urandom, $urandom}, BW'($urandom));
            tick();
        end
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        drive(0, 0, 0, '0, '0);
        repeat (6) tick();
        @(negedge clk_i);
        check("final_empty", DW'(rsp_valid_o), DW'(0));
        check("final_ready", DW'(req_ready_o), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
